// File: rtl/fifo_byte_reader_pkg.sv
// Shared types and sizes for the FIFO byte reader.
// FIFO_BYTE_READER_PARITY_EN adds the PAR state to the state enum.
package fifo_byte_reader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

`ifdef FIFO_BYTE_READER_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_PAR  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/fifo_byte_shifter.sv
// Word shift register and byte index for the FIFO byte reader.
// The outgoing byte always sits at the head of the register; each
// accepted byte shifts the next one into the head position.
module fifo_byte_shifter
    import fifo_byte_reader_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    input  logic              advance,
    output logic [BYTE_W-1:0] cur_byte,
    output logic              last
);

    logic [WORD_W-1:0] sr;
    logic [IDX_W-1:0]  idx;

    // Capture a new word, or shift the next byte to the head on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            idx <= '0;
        end else if (load) begin
            sr  <= data;
            idx <= '0;
        end else if (advance) begin
            if (MSB_FIRST)
                sr <= {sr[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            else
                sr <= {{BYTE_W{1'b0}}, sr[WORD_W-1:BYTE_W]};
            idx <= idx + 1'b1;
        end
    end

    // Head byte and end-of-word flag.
    always_comb begin
        cur_byte = MSB_FIRST ? sr[WORD_W-1 -: BYTE_W] : sr[BYTE_W-1:0];
        last     = (idx == IDX_W'(BYTES_PER_WORD - 1));
    end

endmodule

// File: rtl/fifo_byte_reader.sv
// Reads 32-bit words from a FIFO and serializes them as bytes over a
// valid/ready handshake. Optional macro FIFO_BYTE_READER_PARITY_EN
// appends an XOR parity byte after the four data bytes of each word.
module fifo_byte_reader
    import fifo_byte_reader_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [WORD_W-1:0] fifo_data,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy
);

    state_t            state, state_nxt;
    logic              load, advance, last;
    logic [BYTE_W-1:0] cur_byte;

    fifo_byte_shifter #(.MSB_FIRST(MSB_FIRST)) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (fifo_data),
        .advance  (advance),
        .cur_byte (cur_byte),
        .last     (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Read strobe is a flop that is high exactly while in RD.
    always_ff @(posedge clk) begin
        if (rst) fifo_rd <= 1'b0;
        else     fifo_rd <= (state_nxt == ST_RD);
    end

`ifdef FIFO_BYTE_READER_PARITY_EN
    logic [BYTE_W-1:0] parity;

    // Running XOR of the data bytes actually handed downstream.
    always_ff @(posedge clk) begin
        if (rst)
            parity <= '0;
        else if (load)
            parity <= '0;
        else if (state == ST_SEND && byte_ready)
            parity <= parity ^ cur_byte;
    end
`endif

    // Next-state, handshake and shifter control.
    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        advance    = 1'b0;
        byte_valid = 1'b0;
        byte_out   = '0;
        case (state)
            ST_IDLE: begin
                if (en && !fifo_empty) state_nxt = ST_RD;
            end
            // FIFO sees the strobe here; data arrives during WAIT.
            ST_RD: state_nxt = ST_WAIT;
            ST_WAIT: begin
                load      = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                byte_valid = 1'b1;
                byte_out   = cur_byte;
                if (byte_ready) begin
                    advance = 1'b1;
`ifdef FIFO_BYTE_READER_PARITY_EN
                    if (last) state_nxt = ST_PAR;
`else
                    if (last) state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef FIFO_BYTE_READER_PARITY_EN
            ST_PAR: begin
                byte_valid = 1'b1;
                byte_out   = parity;
                if (byte_ready) state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: doc/fifo_byte_reader.md
FIFO_BYTE_READER -- requirements
Module: fifo_byte_reader

Interface
REQ-001 SHALL have parameter: MSB_FIRST, 1, byte order of serialization (1 = bits 31:24 first; 0 = bits 7:0 first).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: en  input  1  permits starting a new word read.
REQ-005 SHALL have port: fifo_empty  input  1  FIFO empty flag.
REQ-006 SHALL have port: fifo_rd  output  1  FIFO read strobe, registered.
REQ-007 SHALL have port: fifo_data  input  32  FIFO read data, valid the cycle after fifo_rd is sampled.
REQ-008 SHALL have port: byte_out  output  8  serialized byte.
REQ-009 SHALL have port: byte_valid  output  1  byte_out holds a valid byte.
REQ-010 SHALL have port: byte_ready  input  1  downstream accepts the byte.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, RD, WAIT, SEND, and PAR (PAR only with the macro).
REQ-013 IDLE -> RD SHALL occur when en=1 and fifo_empty=0; otherwise the block remains in IDLE.
REQ-014 fifo_rd SHALL be 1 for exactly the one cycle spent in RD, and 0 at all other times.
REQ-015 RD -> WAIT SHALL be unconditional; fifo_empty is not re-sampled after IDLE.
REQ-016 WAIT SHALL capture fifo_data into a 32-bit shift register, clear the byte index to 0, and move to SEND.
REQ-017 In SEND, byte_valid SHALL be 1 and byte_out SHALL show the byte selected by index and MSB_FIRST.
REQ-018 byte_out SHALL hold stable while byte_valid=1 and byte_ready=0.
REQ-019 A byte transfer SHALL occur on a clock edge where byte_valid=1 and byte_ready=1; the index then advances by 1.
REQ-020 The transfer of byte index 3 SHALL move the block to PAR with the macro, or to IDLE without it.
REQ-021 Minimum word period SHALL be 7 cycles (IDLE, RD, WAIT, then 4 SEND cycles with byte_ready held at 1).
REQ-022 en SHALL gate only the IDLE -> RD transition; deasserting en mid-word does not abort the word.
REQ-023 A back-to-back word SHALL start no earlier than the IDLE cycle that follows the last transfer.

Reset
REQ-024 While rst=1, the block SHALL set state=IDLE, fifo_rd=0, byte_valid=0, byte_out=8'h00, busy=0, and clear the shift register, index and parity.
REQ-025 rst asserted mid-word SHALL discard the word; no further bytes are emitted, and the next word is read only after rst deasserts.
REQ-026 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-027 With macro FIFO_BYTE_READER_PARITY_EN defined, the block SHALL keep an 8-bit running XOR of the 4 emitted bytes and, in PAR, present that XOR as a 5th byte under the same valid/ready rules before returning to IDLE.
REQ-028 With FIFO_BYTE_READER_PARITY_EN undefined, the block SHALL contain no PAR state and no parity register, and each word SHALL be exactly 4 bytes.

Structure
REQ-029 Shared package fifo_byte_reader_pkg SHALL hold the state enum, WORD_W=32, BYTE_W=8 and BYTES_PER_WORD=4.
REQ-030 Byte selection, the shift register and the index SHALL live in sub-module fifo_byte_shifter; the FSM and handshake SHALL stay in the top.

Verification
REQ-031 Bench SHALL cover: fifo_empty=1, en=1 for 20 cycles -> fifo_rd never asserts, busy=0.
REQ-032 Bench SHALL cover: word 32'hA1B2C3D4, byte_ready=1, MSB_FIRST=1 -> bytes A1,B2,C3,D4 on consecutive cycles, fifo_rd exactly one pulse, 7-cycle period.
REQ-033 Bench SHALL cover: same word, MSB_FIRST=0, byte_ready low 3 cycles during byte 1 -> D4,C3,B2,A1, with C3 held stable through the stall.
REQ-034 Bench SHALL cover: macro defined, word 32'h01020304 -> 5th byte 8'h04 (01^02^03^04), then IDLE.
REQ-035 Bench SHALL cover: rst pulse after byte 1 of 32'h11223344 -> byte_valid=0 the next cycle; the next FIFO word 32'h55667788 is emitted in full.
REQ-036 Bench SHALL cover: en dropped during SEND of two queued words -> first word completes, second is not read until en=1.
